// File: rtl/tim_cnt_ctrl_if.sv
// Control/status bundle between the timer register block and the counter controller.
// The register block drives commands as master; the counter controller is the slave.
interface tim_cnt_ctrl_if;
    logic        timer_en;
    logic        div_en;
    logic [3:0]  div_val;
    logic        halt_req;
    logic        dbg_mode;
    logic        counter_clear;
    logic [1:0]  counter_write_sel;
    logic [31:0] counter_write_data;
    logic [63:0] cnt_val;
    logic        cnt_step;
    logic        halt_ack_status;

    modport master (
        output timer_en, div_en, div_val, halt_req, dbg_mode,
               counter_clear, counter_write_sel, counter_write_data,
        input  cnt_val, cnt_step, halt_ack_status
    );

    modport slave (
        input  timer_en, div_en, div_val, halt_req, dbg_mode,
               counter_clear, counter_write_sel, counter_write_data,
        output cnt_val, cnt_step, halt_ack_status
    );
endinterface

// File: rtl/tim_cnt_ctrl.sv
// Timer counter controller: prescaler, debug-halt handshake FSM and 64-bit counter
// with clear > word write > increment priority.
module tim_cnt_ctrl #(
    parameter int unsigned DIV_MAX     = 8,
    parameter logic [63:0] CNT_RST_VAL = 64'h0
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    tim_cnt_ctrl_if.slave bus
);

    localparam logic [3:0] LP_DIV_MAX = 4'(DIV_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t      r_state;
    logic        r_halt_ack;
    logic [7:0]  r_div_cnt;
    logic        r_div_en_q;
    logic [3:0]  r_div_val_q;
    logic [63:0] r_cnt;

    logic        w_halt_cond;
    logic        w_run_entry;
    logic        w_cfg_chg;
    logic [3:0]  w_eff;
    logic [7:0]  w_div_term_val;
    logic        w_div_term;
    logic        w_step;

    assign w_halt_cond = bus.halt_req && bus.dbg_mode;
    assign w_run_entry = (r_state == ST_IDLE) && bus.timer_en && !w_halt_cond;
    assign w_cfg_chg   = (bus.div_en != r_div_en_q) || (bus.div_val != r_div_val_q);

    // Shifting past the 8-bit width yields 0, so eff=8 gives a terminal count of 8'hFF.
    assign w_eff          = (bus.div_val > LP_DIV_MAX) ? LP_DIV_MAX : bus.div_val;
    assign w_div_term_val = ~(8'hFF << w_eff);
    assign w_div_term     = !bus.div_en || (r_div_cnt == w_div_term_val);
    assign w_step         = (r_state == ST_RUN) && w_div_term;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_halt_ack <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_halt_cond) begin
                        r_state    <= ST_HALTED;
                        r_halt_ack <= 1'b1;
                    end else if (bus.timer_en) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_halt_cond) begin
                        r_state    <= ST_HALTED;
                        r_halt_ack <= 1'b1;
                    end else if (!bus.timer_en) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    if (!w_halt_cond) begin
                        r_state    <= bus.timer_en ? ST_RUN : ST_IDLE;
                        r_halt_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_halt_ack <= 1'b0;
                end
            endcase
        end
    end

    // Prescaler phase is held outside RUN so a halt does not disturb it.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_div_cnt   <= 8'd0;
            r_div_en_q  <= 1'b0;
            r_div_val_q <= 4'd0;
        end else begin
            r_div_en_q  <= bus.div_en;
            r_div_val_q <= bus.div_val;
            if (bus.counter_clear || w_cfg_chg || w_run_entry) begin
                r_div_cnt <= 8'd0;
            end else if (r_state == ST_RUN) begin
                r_div_cnt <= w_div_term ? 8'd0 : r_div_cnt + 8'd1;
            end
        end
    end

    // A write wins over a same-cycle step; the step is dropped, not deferred.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt <= CNT_RST_VAL;
        end else if (bus.counter_clear) begin
            r_cnt <= CNT_RST_VAL;
        end else if (|bus.counter_write_sel) begin
            if (bus.counter_write_sel[0]) r_cnt[31:0]  <= bus.counter_write_data;
            if (bus.counter_write_sel[1]) r_cnt[63:32] <= bus.counter_write_data;
        end else if (w_step) begin
            r_cnt <= r_cnt + 64'd1;
        end
    end

    assign bus.cnt_val         = r_cnt;
    assign bus.cnt_step        = w_step;
    assign bus.halt_ack_status = r_halt_ack;

endmodule

// File: tb/tb_tim_cnt_ctrl.sv
// Directed, table-driven bench for tim_cnt_ctrl: each row is one clock cycle,
// outputs are compared mid-cycle before the edge that consumes that row's inputs.
module tb_tim_cnt_ctrl;

    logic sys_clk;
    logic sys_rst;

    tim_cnt_ctrl_if bus ();

    tim_cnt_ctrl #(
        .DIV_MAX    (8),
        .CNT_RST_VAL(64'h0)
    ) u_dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          rst_b;
        bit          te;
        bit          de;
        logic [3:0]  dv;
        bit          hr;
        bit          dm;
        bit          clr;
        logic [1:0]  sel;
        logic [31:0] wd;
        logic [63:0] exp_cnt;
        bit          exp_step;
        bit          exp_ack;
        string       nm;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(bit rst_b, bit te, bit de, logic [3:0] dv, bit hr, bit dm,
                                bit clr, logic [1:0] sel, logic [31:0] wd,
                                logic [63:0] ec, bit es, bit ea, string nm);
        vec_t v;
        v.rst_b = rst_b; v.te = te; v.de = de; v.dv = dv; v.hr = hr; v.dm = dm;
        v.clr = clr; v.sel = sel; v.wd = wd;
        v.exp_cnt = ec; v.exp_step = es; v.exp_ack = ea; v.nm = nm;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit te, input bit de, input logic [3:0] dv, input bit hr,
                         input bit dm, input bit clr, input logic [1:0] sel,
                         input logic [31:0] wd);
        bus.timer_en           = te;
        bus.div_en             = de;
        bus.div_val            = dv;
        bus.halt_req           = hr;
        bus.dbg_mode           = dm;
        bus.counter_clear      = clr;
        bus.counter_write_sel  = sel;
        bus.counter_write_data = wd;
    endtask

    // Called 1 ns after a rising edge; the pulse ends well before the next edge.
    task automatic pulse_reset();
        sys_rst = 1'b1;
        #1;
        sys_rst = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        if (v.rst_b) pulse_reset();
        drive(v.te, v.de, v.dv, v.hr, v.dm, v.clr, v.sel, v.wd);
        @(negedge sys_clk);
        check($sformatf("%s/cnt", v.nm),  bus.cnt_val,         v.exp_cnt);
        check($sformatf("%s/step", v.nm), bus.cnt_step,        v.exp_step);
        check($sformatf("%s/ack", v.nm),  bus.halt_ack_status, v.exp_ack);
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit found;

        // Free-running count, no prescale: first step one cycle after timer_en is seen.
        vecs.push_back(mk(1, 0, 0, 4'd0, 0, 0, 0, 2'b00, 32'h0, 64'd0, 0, 0, "rst"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 2'b00, 32'h0, 64'd0, 0, 0, "en_idle"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 2'b00, 32'h0, 64'd0, 1, 0, "run0"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 2'b00, 32'h0, 64'd1, 1, 0, "run1"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 2'b00, 32'h0, 64'd2, 1, 0, "run2"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 2'b00, 32'h0, 64'd3, 1, 0, "run3"));

        // div_val=2: one step per 4 RUN cycles, on the 4th.
        vecs.push_back(mk(1, 0, 1, 4'd2, 0, 0, 0, 2'b00, 32'h0, 64'd0, 0, 0, "div2_cfg"));
        vecs.push_back(mk(0, 1, 1, 4'd2, 0, 0, 0, 2'b00, 32'h0, 64'd0, 0, 0, "div2_en"));
        for (int k = 1; k <= 12; k++)
            vecs.push_back(mk(0, 1, 1, 4'd2, 0, 0, 0, 2'b00, 32'h0, 64'((k - 1) / 4),
                              (k % 4) == 0, 0, $sformatf("div2_c%0d", k)));
        vecs.push_back(mk(0, 1, 1, 4'd2, 0, 0, 0, 2'b00, 32'h0, 64'd3, 0, 0, "div2_c13"));

        // Word writes, carry, wrap, write/clear priority, halt without and with dbg_mode.
        vecs.push_back(mk(1, 0, 0, 4'd0, 0, 0, 0, 2'b01, 32'hFFFF_FFFF, 64'd0, 0, 0, "wr_lo"));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 0, 0, 2'b10, 32'h0, 64'h0000_0000_FFFF_FFFF, 0, 0, "wr_hi"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 2'b00, 32'h0, 64'h0000_0000_FFFF_FFFF, 0, 0, "wr_en"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 2'b00, 32'h0, 64'h0000_0000_FFFF_FFFF, 1, 0, "carry"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 2'b11, 32'hFFFF_FFFF, 64'h0000_0001_0000_0000, 1, 0, "wr_ones"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 2'b00, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, "wrap"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 2'b01, 32'h1234_5678, 64'd0, 1, 0, "wr_step_lo"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 2'b10, 32'h0000_000A, 64'h0000_0000_1234_5678, 1, 0, "wr_step_hi"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 1, 2'b01, 32'h5, 64'h0000_000A_1234_5678, 1, 0, "clr_wr_step"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 2'b00, 32'h0, 64'd0, 1, 0, "after_clr"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 0, 0, 2'b00, 32'h0, 64'd1, 1, 0, "hreq_nodbg0"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 0, 0, 2'b00, 32'h0, 64'd2, 1, 0, "hreq_nodbg1"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 1, 0, 2'b00, 32'h0, 64'd3, 1, 0, "halt_req"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 1, 0, 2'b00, 32'h0, 64'd4, 0, 1, "halted0"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 1, 1, 2'b00, 32'h0, 64'd4, 0, 1, "halted_clr"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 1, 0, 2'b00, 32'h0, 64'd0, 0, 1, "halted1"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 0, 2'b00, 32'h0, 64'd0, 0, 1, "release"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 0, 2'b00, 32'h0, 64'd0, 1, 0, "resumed0"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 0, 2'b00, 32'h0, 64'd1, 1, 0, "resumed1"));

        // Halt mid-prescale: div_val=3, halt sampled while div_cnt=5; phase held across halt.
        vecs.push_back(mk(1, 0, 1, 4'd3, 0, 0, 0, 2'b00, 32'h0, 64'd0, 0, 0, "ph_cfg"));
        vecs.push_back(mk(0, 1, 1, 4'd3, 0, 0, 0, 2'b00, 32'h0, 64'd0, 0, 0, "ph_en"));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 1, 1, 4'd3, 0, 0, 0, 2'b00, 32'h0, 64'd0, 0, 0,
                              $sformatf("ph_dc%0d", k)));
        vecs.push_back(mk(0, 1, 1, 4'd3, 1, 1, 0, 2'b00, 32'h0, 64'd0, 0, 0, "ph_halt_dc5"));
        vecs.push_back(mk(0, 1, 1, 4'd3, 1, 1, 0, 2'b00, 32'h0, 64'd0, 0, 1, "ph_halted0"));
        vecs.push_back(mk(0, 1, 1, 4'd3, 1, 1, 0, 2'b00, 32'h0, 64'd0, 0, 1, "ph_halted1"));
        vecs.push_back(mk(0, 1, 1, 4'd3, 0, 1, 0, 2'b00, 32'h0, 64'd0, 0, 1, "ph_release"));
        vecs.push_back(mk(0, 1, 1, 4'd3, 0, 1, 0, 2'b00, 32'h0, 64'd0, 0, 0, "ph_dc6"));
        vecs.push_back(mk(0, 1, 1, 4'd3, 0, 1, 0, 2'b00, 32'h0, 64'd0, 1, 0, "ph_dc7"));
        vecs.push_back(mk(0, 1, 1, 4'd3, 0, 1, 0, 2'b00, 32'h0, 64'd1, 0, 0, "ph_after"));

        sys_rst = 1'b1;
        drive(0, 0, 4'd0, 0, 0, 0, 2'b00, 32'h0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // div_val=4'hF saturates to 8: step period of 256 cycles, measured twice.
        pulse_reset();
        drive(0, 1, 4'hF, 0, 0, 0, 2'b00, 32'h0);
        @(posedge sys_clk);
        #1;
        bus.timer_en = 1'b1;
        @(posedge sys_clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            n = 0;
            found = 1'b0;
            while (!found && n < 400) begin
                @(negedge sys_clk);
                n++;
                if (bus.cnt_step) found = 1'b1;
                @(posedge sys_clk);
                #1;
            end
            check($sformatf("sat_period%0d", p), 64'(n), 64'd256);
        end
        @(negedge sys_clk);
        check("sat_cnt", bus.cnt_val, 64'd2);
        @(posedge sys_clk);
        #1;

        // Halt from IDLE, write while HALTED, then asynchronous reset mid-cycle.
        pulse_reset();
        drive(0, 0, 4'd0, 1, 1, 0, 2'b00, 32'h0);
        @(posedge sys_clk);
        #1;
        bus.counter_write_sel  = 2'b11;
        bus.counter_write_data = 32'hDEAD_BEEF;
        @(negedge sys_clk);
        check("idle_halt_ack", bus.halt_ack_status, 1'b1);
        @(posedge sys_clk);
        #1;
        bus.counter_write_sel = 2'b00;
        @(negedge sys_clk);
        check("halted_wr_cnt", bus.cnt_val, 64'hDEAD_BEEF_DEAD_BEEF);
        check("halted_wr_ack", bus.halt_ack_status, 1'b1);
        sys_rst = 1'b1;
        #1;
        check("async_rst_ack", bus.halt_ack_status, 1'b0);
        check("async_rst_cnt", bus.cnt_val, 64'd0);
        bus.halt_req = 1'b0;
        bus.timer_en = 1'b1;
        #1;
        sys_rst = 1'b0;
        #1;
        check("post_rst_step", bus.cnt_step, 1'b0);
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        check("post_rst_run_step", bus.cnt_step, 1'b1);
        check("post_rst_run_cnt", bus.cnt_val, 64'd0);
        @(posedge sys_clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tim_cnt_ctrl.md
Name: tim_cnt_ctrl

Overview:
Counter controller for the timer. It sequences the 64-bit count datapath: a prescaler produces the count steps, and a halt-handshake state machine serves debug halt requests. It also arbitrates between clear, APB word writes (TDR0/TDR1) and increment on the counter. It sits between the register block, which supplies control and command inputs, and the interrupt block, which consumes cnt_val.

Parameters:
DIV_MAX, 8, largest legal div_val; larger values saturate to DIV_MAX.
CNT_RST_VAL, 64'h0, counter value after reset and after counter_clear.

Ports:
sys_clk  input  1  system clock, all state on rising edge
sys_rst  input  1  asynchronous reset, active-high
timer_en  input  1  counting enabled (TCR[0])
div_en  input  1  prescaler enabled (TCR[1])
div_val  input  4  prescale exponent; step period is 2^div_val cycles
halt_req  input  1  debug halt request (THCSR[0])
dbg_mode  input  1  CPU in debug mode; halt is honoured only when high
counter_clear  input  1  one-cycle pulse: reload CNT_RST_VAL
counter_write_sel  input  2  bit0 writes cnt[31:0], bit1 writes cnt[63:32]
counter_write_data  input  32  write data for the selected word(s)
cnt_val  output  64  current count
cnt_step  output  1  one-cycle pulse in cycles where an increment is applied
halt_ack_status  output  1  high while the counter is frozen by halt (THCSR[1])

Behaviour:
- Reset (sys_rst=1, asynchronous): cnt_val=CNT_RST_VAL, cnt_step=0, halt_ack_status=0, prescaler count=0, FSM=IDLE.
- FSM states are IDLE, RUN and HALTED.
  - IDLE -> RUN when timer_en=1.
  - RUN -> IDLE when timer_en=0.
  - RUN -> HALTED when halt_req && dbg_mode.
  - HALTED -> RUN when !(halt_req && dbg_mode) && timer_en.
  - HALTED -> IDLE when !(halt_req && dbg_mode) && !timer_en.
  - IDLE with halt_req && dbg_mode -> HALTED (acknowledged even when the timer is stopped).
- halt_ack_status is registered and equals (state==HALTED). It rises 1 cycle after the halt condition is sampled and falls 1 cycle after the condition drops.
- Prescaler (8-bit div_cnt, counts only in RUN):
  - div_en=0: step every RUN cycle.
  - div_en=1: eff = min(div_val, DIV_MAX). The step is asserted when div_cnt == 2^eff − 1, and div_cnt then wraps to 0; otherwise div_cnt increments.
  - eff=0 steps every cycle, same as div_en=0.
  - div_cnt resets to 0 on entry to RUN from IDLE, on counter_clear, and whenever div_en or div_val changes value (registered copies compared).
  - div_cnt holds its value in HALTED, so the prescale phase resumes seamlessly after halt.
- cnt_step is combinational from the registered state: (state==RUN) && prescale terminal.
- Counter update priority, one per cycle, highest first:
  1. counter_clear -> CNT_RST_VAL.
  2. Any counter_write_sel bit set -> selected word(s) load counter_write_data; unselected word holds. If both bits are set, both words take the same data. A step in the same cycle is discarded.
  3. cnt_step -> cnt_val+1, with wrap 64'hFFFF_FFFF_FFFF_FFFF -> 0.
  4. Otherwise hold.
- Carry from the low word into the high word is single-cycle (full 64-bit add); no carry is generated on writes.
- Writes and clear are accepted in every state, including HALTED and IDLE.
- timer_en falling edge: counting stops that cycle and the value holds. Clearing is done only via counter_clear.
- halt_req asserted without dbg_mode: ignored and counting continues.
- Asynchronous reset mid-count or mid-halt returns everything to reset values immediately. First step after release is no earlier than 1 cycle after timer_en is seen.

Test Plan:
- Reset, then timer_en=1, div_en=0 -> cnt_val 0,1,2,3 on consecutive cycles; cnt_step high every cycle.
- div_en=1, div_val=2 -> cnt_step every 4th cycle; cnt_val=3 after 12 RUN cycles. div_val=4'hF -> period 256 (saturated to 8).
- Load cnt=64'h0000_0000_FFFF_FFFF via sel=2'b01 then 2'b10 with data 0, run 1 step -> 64'h0000_0001_0000_0000. Load all ones, step -> 0.
- halt_req=1, dbg_mode=1 mid-prescale (div_val=3, div_cnt=5) -> halt_ack_status=1 next cycle, cnt_val frozen. Release -> ack drops, next step after 2 cycles.
- counter_clear, counter_write_sel=2'b01 and cnt_step in the same cycle -> cnt_val=CNT_RST_VAL. Write plus step -> written value exactly, no +1.
- halt_req=1 with dbg_mode=0 -> no ack, counting continues. Assert sys_rst while HALTED -> ack=0 and cnt_val=0 immediately.
